// File: rtl/issue_scoreboard_if.sv
// Decode-to-execute issue bus: per-requester issue requests, writeback strobes,
// and the scheduler's grant/hazard/scoreboard view.
interface issue_scoreboard_if #(parameter int PNUMS = 2);
  logic                 FLUSH;
  logic                 STALL;
  logic [PNUMS-1:0]     REQ_VALID;
  logic [5*PNUMS-1:0]   REQ_RD;
  logic [5*PNUMS-1:0]   REQ_RS1;
  logic [5*PNUMS-1:0]   REQ_RS2;
  logic [PNUMS-1:0]     WB_VALID;
  logic [5*PNUMS-1:0]   WB_RD;
  logic [PNUMS-1:0]     GRANT;
  logic [4:0]           GRANT_RD;
  logic [PNUMS-1:0]     HAZARD;
  logic [31:0]          BUSY_MASK;

  modport master (
    output FLUSH, STALL, REQ_VALID, REQ_RD, REQ_RS1, REQ_RS2, WB_VALID, WB_RD,
    input  GRANT, GRANT_RD, HAZARD, BUSY_MASK
  );

  modport slave (
    input  FLUSH, STALL, REQ_VALID, REQ_RD, REQ_RS1, REQ_RS2, WB_VALID, WB_RD,
    output GRANT, GRANT_RD, HAZARD, BUSY_MASK
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-issue round-robin scheduler with a 32-entry busy-register scoreboard.
// Requester 0 is the main stream; 1..COP_NUMS are coprocessor streams.

module isb_elig (
  input  logic [31:0] busy_i,
  input  logic        valid_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  output logic        elig_o,
  output logic        hazard_o
);
  logic blocked;

  // busy_i[0] is always low, so x0 operands never block
  assign blocked  = busy_i[rd_i] | busy_i[rs1_i] | busy_i[rs2_i];
  assign elig_o   = valid_i & ~blocked;
  assign hazard_o = valid_i & blocked;
endmodule

module issue_scoreboard #(
  parameter int COP_NUMS = 1,
  parameter int PNUMS    = COP_NUMS + 1
) (
  input  logic              CLK,
  input  logic              RST,
  issue_scoreboard_if.slave bus
);
  localparam int            PW      = (PNUMS > 1) ? $clog2(PNUMS) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(PNUMS - 1);

  logic [31:0]      busy_q, busy_d;
  logic [31:0]      wb_clr, busy_eff;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gidx;
  logic [PW:0]      arb_j;
  logic [PNUMS-1:0] elig, hazard, grant;
  logic             gnt_en, gnt_any;
  logic [4:0]       grd;

  always_comb begin
    wb_clr = '0;
    for (int i = 0; i < PNUMS; i++)
      if (bus.WB_VALID[i]) wb_clr[bus.WB_RD[5*i +: 5]] = 1'b1;
  end

  // Same-cycle writeback bypasses the registered scoreboard
  assign busy_eff = {busy_q[31:1] & ~wb_clr[31:1], 1'b0};

  for (genvar g = 0; g < PNUMS; g++) begin : g_lane
    isb_elig u_elig (
      .busy_i   (busy_eff),
      .valid_i  (bus.REQ_VALID[g]),
      .rd_i     (bus.REQ_RD[5*g +: 5]),
      .rs1_i    (bus.REQ_RS1[5*g +: 5]),
      .rs2_i    (bus.REQ_RS2[5*g +: 5]),
      .elig_o   (elig[g]),
      .hazard_o (hazard[g])
    );
  end

  assign gnt_en = ~RST & ~bus.FLUSH & ~bus.STALL;

  // Search starts one past the last winner and wraps
  always_comb begin
    gnt_any = 1'b0;
    gidx    = ptr_q;
    arb_j   = '0;
    for (int k = 1; k <= PNUMS; k++) begin
      arb_j = {1'b0, ptr_q} + (PW+1)'(k);
      if (arb_j >= (PW+1)'(PNUMS)) arb_j = arb_j - (PW+1)'(PNUMS);
      if (!gnt_any && elig[arb_j[PW-1:0]]) begin
        gnt_any = 1'b1;
        gidx    = arb_j[PW-1:0];
      end
    end
    gnt_any = gnt_any & gnt_en;
  end

  always_comb begin
    grant = '0;
    grd   = '0;
    for (int i = 0; i < PNUMS; i++)
      if (gnt_any && gidx == PW'(i)) begin
        grant[i] = 1'b1;
        grd      = bus.REQ_RD[5*i +: 5];
      end
  end

  // Set after clear: a new producer owns the register over a retiring one
  always_comb begin
    busy_d = busy_eff;
    ptr_d  = ptr_q;
    if (gnt_any) begin
      ptr_d = gidx;
      if (grd != 5'd0) busy_d[grd] = 1'b1;
    end
    if (bus.FLUSH) begin
      busy_d = '0;
      ptr_d  = PTR_RST;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= '0;
      ptr_q  <= PTR_RST;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.GRANT     = grant;
  assign bus.GRANT_RD  = grd;
  assign bus.HAZARD    = hazard;
  assign bus.BUSY_MASK = busy_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed walk through the issue scenarios, then random traffic checked
// against a register-set model of the scoreboard and round-robin order.
module tb_issue_scoreboard;
  localparam int COP_NUMS = 1;
  localparam int P        = COP_NUMS + 1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  issue_scoreboard_if #(.PNUMS(P)) bus ();

  issue_scoreboard #(.COP_NUMS(COP_NUMS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_run  = 0;
  int n_fail = 0;

  bit mbusy [32];
  int mptr;

  logic [P-1:0] last_grant, last_haz;
  logic [4:0]   last_grd;
  bit           pend [P];
  logic [P-1:0] seq [4];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wb_hit(int r);
    for (int j = 0; j < P; j++)
      if (bus.WB_VALID[j] && int'(bus.WB_RD[5*j +: 5]) == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit reg_busy(int r);
    return (r != 0) && mbusy[r] && !wb_hit(r);
  endfunction

  task automatic set_req(int i, bit v, int rd, int rs1, int rs2);
    bus.REQ_VALID[i]       = v;
    bus.REQ_RD[5*i +: 5]   = 5'(rd);
    bus.REQ_RS1[5*i +: 5]  = 5'(rs1);
    bus.REQ_RS2[5*i +: 5]  = 5'(rs2);
  endtask

  task automatic set_wb(int i, bit v, int rd);
    bus.WB_VALID[i]     = v;
    bus.WB_RD[5*i +: 5] = 5'(rd);
  endtask

  task automatic idle();
    for (int i = 0; i < P; i++) begin
      set_req(i, 1'b0, 0, 0, 0);
      set_wb(i, 1'b0, 0);
    end
    bus.FLUSH = 1'b0;
    bus.STALL = 1'b0;
  endtask

  // Check combinational outputs against the model, clock once, advance the model
  task automatic step(string tag);
    bit           el [P];
    int           rdv [P];
    logic [P-1:0] eg, eh;
    logic [4:0]   erd;
    logic [31:0]  ebm;
    int           gi;
    bit           clr_all;
    #2;
    eh = '0;
    for (int i = 0; i < P; i++) begin
      bit blk;
      rdv[i] = int'(bus.REQ_RD[5*i +: 5]);
      blk = reg_busy(rdv[i]) || reg_busy(int'(bus.REQ_RS1[5*i +: 5])) ||
            reg_busy(int'(bus.REQ_RS2[5*i +: 5]));
      el[i] = bus.REQ_VALID[i] && !blk;
      eh[i] = bus.REQ_VALID[i] && blk;
    end
    gi = -1;
    if (!RST && !bus.FLUSH && !bus.STALL)
      for (int k = 1; k <= P; k++) begin
        int j;
        j = (mptr + k) % P;
        if (gi < 0 && el[j]) gi = j;
      end
    eg  = '0;
    erd = '0;
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      erd    = 5'(rdv[gi]);
    end
    for (int r = 0; r < 32; r++) ebm[r] = mbusy[r];
    chk({tag, "_grant"},  32'(bus.GRANT),    32'(eg));
    chk({tag, "_grd"},    32'(bus.GRANT_RD), 32'(erd));
    chk({tag, "_hazard"}, 32'(bus.HAZARD),   32'(eh));
    chk({tag, "_busy"},   bus.BUSY_MASK,     ebm);
    last_grant = bus.GRANT;
    last_haz   = bus.HAZARD;
    last_grd   = bus.GRANT_RD;
    clr_all    = RST || bus.FLUSH;
    @(posedge CLK);
    if (clr_all) begin
      for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
      mptr = P - 1;
    end else begin
      for (int r = 1; r < 32; r++) if (wb_hit(r)) mbusy[r] = 1'b0;
      if (gi >= 0) begin
        mptr = gi;
        if (erd != 0) mbusy[erd] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    mptr = P - 1;
    step("rst");
    chk("rst_busy", bus.BUSY_MASK, 32'h0);
    chk("rst_grant", 32'(last_grant), 32'h0);
    RST = 1'b0;

    // 1: simple grant, rd 5 marked busy
    set_req(0, 1, 5, 1, 2);
    step("t1");
    chk("t1_grant", 32'(last_grant), 32'h1);
    chk("t1_grd", 32'(last_grd), 32'd5);
    idle();
    chk("t1_busy", bus.BUSY_MASK, 32'h20);

    // 2: RAW hazard, then writeback bypass with re-set of rd 5
    set_req(0, 1, 5, 5, 0);
    step("t2a");
    chk("t2_hazard", 32'(last_haz), 32'h1);
    chk("t2_nogrant", 32'(last_grant), 32'h0);
    set_wb(1, 1, 5);
    step("t2b");
    chk("t2_bypass", 32'(last_grant), 32'h1);
    idle();
    chk("t2_busy", bus.BUSY_MASK, 32'h20);
    set_wb(0, 1, 5);
    step("t2c");
    idle();
    chk("t2_clear", bus.BUSY_MASK, 32'h0);

    // 3: round robin from reset, rd=0 never sets busy
    RST = 1'b1;
    step("t3rst");
    RST = 1'b0;
    set_req(0, 1, 0, 1, 2);
    set_req(1, 1, 0, 3, 4);
    for (int c = 0; c < 4; c++) begin
      step("t3");
      seq[c] = last_grant;
    end
    chk("t3_seq0", 32'(seq[0]), 32'h1);
    chk("t3_seq1", 32'(seq[1]), 32'h2);
    chk("t3_seq2", 32'(seq[2]), 32'h1);
    chk("t3_seq3", 32'(seq[3]), 32'h2);
    chk("t3_busy", bus.BUSY_MASK, 32'h0);
    idle();

    // 4: main blocked on rs2=7, coprocessor slips past
    set_req(0, 1, 7, 0, 0);
    step("t4a");
    chk("t4_main", 32'(last_grant), 32'h1);
    set_req(0, 1, 0, 0, 7);
    set_req(1, 1, 9, 1, 2);
    step("t4b");
    chk("t4_cop", 32'(last_grant), 32'h2);
    chk("t4_haz", 32'(last_haz), 32'h1);
    set_req(1, 0, 0, 0, 0);
    chk("t4_busy", bus.BUSY_MASK, 32'h280);
    step("t4c");
    chk("t4_haz2", 32'(last_haz), 32'h1);
    set_wb(1, 1, 7);
    step("t4d");
    chk("t4_wbgrant", 32'(last_grant), 32'h1);
    idle();

    // 5: stall blocks grants but not writeback
    set_req(0, 1, 0, 1, 2);
    set_req(1, 1, 0, 3, 4);
    bus.STALL = 1'b1;
    set_wb(1, 1, 9);
    step("t5a");
    chk("t5_stall", 32'(last_grant), 32'h0);
    chk("t5_wb", bus.BUSY_MASK, 32'h0);
    set_wb(1, 0, 0);
    step("t5b");
    bus.STALL = 1'b0;
    step("t5c");
    chk("t5_resume", 32'(last_grant), 32'h2);
    step("t5d");
    chk("t5_next", 32'(last_grant), 32'h1);
    idle();

    // 6: flush, then reset, each from BUSY_MASK=0x220 with ptr on main
    for (int pass = 0; pass < 2; pass++) begin
      set_req(1, 1, 9, 1, 2);
      step("t6a");
      set_req(1, 0, 0, 0, 0);
      set_req(0, 1, 5, 1, 2);
      step("t6b");
      idle();
      chk("t6_busy", bus.BUSY_MASK, 32'h220);
      set_req(0, 1, 0, 1, 2);
      set_req(1, 1, 0, 3, 4);
      if (pass == 0) bus.FLUSH = 1'b1; else RST = 1'b1;
      step("t6c");
      chk("t6_nogrant", 32'(last_grant), 32'h0);
      bus.FLUSH = 1'b0;
      RST = 1'b0;
      chk("t6_cleared", bus.BUSY_MASK, 32'h0);
      step("t6d");
      chk("t6_main", 32'(last_grant), 32'h1);
      idle();
    end

    // Random traffic; requesters hold until granted
    for (int i = 0; i < P; i++) pend[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          set_req(i, 1, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                  int'($urandom_range(7, 0)));
          pend[i] = 1'b1;
        end
        set_wb(i, $urandom_range(2, 0) == 0, int'($urandom_range(7, 0)));
      end
      bus.STALL = ($urandom_range(9, 0) == 0);
      bus.FLUSH = ($urandom_range(59, 0) == 0);
      RST       = ($urandom_range(199, 0) == 0);
      step("rnd");
      for (int i = 0; i < P; i++)
        if (last_grant[i]) begin
          pend[i] = 1'b0;
          set_req(i, 0, 0, 0, 0);
        end
    end
    RST = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Single-issue scheduler between decode and execute.
- Arbitrates among the main stream (requester 0) and COP_NUMS coprocessor streams (requesters 1..COP_NUMS).
- Tracks in-flight destination registers in a 32-entry busy scoreboard.
- Grants at most one hazard-free request per cycle; clears busy bits on writeback.

Parameters:
- COP_NUMS, 1, number of coprocessor requesters.
- PNUMS, COP_NUMS+1, total requesters; index 0 = main.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- FLUSH  in  1  clear scoreboard and RR pointer; suppress grant this cycle
- STALL  in  1  downstream stall; no grant, no pointer/busy-set update
- REQ_VALID  in  PNUMS  per-requester issue request
- REQ_RD  in  5*PNUMS  destination reg, packed, requester i at [5i+4:5i]
- REQ_RS1  in  5*PNUMS  source 1, packed
- REQ_RS2  in  5*PNUMS  source 2, packed
- WB_VALID  in  PNUMS  per-unit writeback strobe
- WB_RD  in  5*PNUMS  writeback destination, packed
- GRANT  out  PNUMS  one-hot issue grant (combinational)
- GRANT_RD  out  5  rd of granted request; 0 when no grant
- HAZARD  out  PNUMS  request valid but blocked by scoreboard (combinational)
- BUSY_MASK  out  32  registered scoreboard; bit0 always 0

Behaviour:
- Reset: BUSY_MASK=0, RR pointer=PNUMS-1 (main searched first).
- Reset has priority over FLUSH and STALL.
- Reset mid-operation discards all busy state; GRANT=0 during the RST cycle.
- Eligibility: requester i is eligible iff REQ_VALID[i] and none of rs1/rs2/rd is busy.
  - Busy = BUSY_MASK bit set AND not cleared by a WB in the same cycle (writeback bypass).
  - Register x0 never blocks.
  - rd busy blocks the request (WAW).
- HAZARD[i] = REQ_VALID[i] && !eligible[i], independent of STALL and FLUSH.
- Arbitration: round-robin over eligible requesters.
  - Search starts at (ptr+1) mod PNUMS; first eligible wins.
  - GRANT=0 if FLUSH, STALL or RST is high.
- Grant latency: 0 cycles (combinational).
  - Scoreboard set and pointer update take effect at the next CLK edge.
  - On grant: ptr<=granted index; if rd!=0, BUSY_MASK[rd]<=1.
- Writeback: for each i with WB_VALID[i] and WB_RD!=0, BUSY_MASK[WB_RD]<=0.
  - WB applies even during STALL.
  - Multiple WB to the same reg in one cycle = single clear.
- Same-cycle set and clear of the same reg: set wins (new producer owns the reg).
- FLUSH: BUSY_MASK<=0, ptr<=PNUMS-1, no grant. Takes priority over STALL and WB.
- STALL: BUSY_MASK changes only by WB; ptr holds.
- No request is ever dropped by the block: a requester holds REQ_VALID until it sees GRANT[i].
- WB to a reg that is not busy is harmless (no-op).

Test Plan (COP_NUMS=1, PNUMS=2):
1. Reset, then REQ_VALID=01, rd=5, rs=1/2 -> GRANT=01, GRANT_RD=5; next cycle BUSY_MASK=0x20.
2. BUSY_MASK=0x20; main requests rs1=5 -> HAZARD=01, GRANT=00.
   - Then WB_VALID=10, WB_RD=5 in the same cycle -> GRANT=01 (bypass); BUSY_MASK[5] remains 1 (new set).
3. Both requesters valid, no hazards, held 4 cycles, rd=0 -> GRANT sequence 01,10,01,10; BUSY_MASK stays 0.
4. Main blocked on rs2=7 busy, cop valid rd=9 -> GRANT=10; BUSY_MASK gains bit9; main HAZARD=1 until WB of rd 7.
5. STALL=1 with both valid -> GRANT=00, ptr unchanged.
   - WB_RD=9 during STALL still clears bit9.
   - Release STALL -> grant resumes at the expected RR index.
6. BUSY_MASK=0x0000_0220, FLUSH=1 with REQ_VALID=11 -> GRANT=00; next cycle BUSY_MASK=0; next grant goes to main. Repeat with RST in place of FLUSH -> same result.
